// File: rtl/wshb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wshb_arb_pkg
// Description : Shared types and constants for the Wishbone round-robin
//               arbiter (state encoding, Wishbone cycle-type codes, limits).
// Revision    : 1.0 - initial release
// ============================================================================
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Wishbone registered-feedback cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int NREQ_MAX = 8;

endpackage : wshb_arb_pkg
`default_nettype wire

// File: rtl/wshb_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : wshb_rr_picker
// Description : Combinational round-robin winner selection. Searches the
//               request vector starting one position after the previous
//               owner and wrapping around, so the previous owner is the
//               lowest-priority candidate.
// Ports       : req  [NREQ] in  - pending requests
//               last [NREQ] in  - previous owner, one-hot
//               next [NREQ] out - selected winner, one-hot (0 if no request)
// Revision    : 1.0 - initial release
// ============================================================================
module wshb_rr_picker #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] last,
  output logic [NREQ-1:0] next
);

  logic [NREQ-1:0]   w_upper;
  logic [2*NREQ-1:0] w_dbl;
  logic              w_found;

  // last | (last-1) covers every position at or below the previous owner;
  // its complement keeps only requesters strictly after it.
  assign w_upper = req & ~(last | (last - NREQ'(1)));

  // Lower half: requesters after the previous owner. Upper half: the full
  // request vector, providing the wrap-around (owner itself comes last).
  assign w_dbl = {req, w_upper};

  always_comb begin
    next    = '0;
    w_found = 1'b0;
    for (int i = 0; i < 2*NREQ; i++) begin
      if (w_dbl[i] && !w_found) begin
        next[i % NREQ] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule : wshb_rr_picker
`default_nettype wire

// File: rtl/wshb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wshb_rr_arbiter
// Description : Round-robin arbiter placing NREQ Wishbone masters onto one
//               shared slave port. Registered one-hot grant, one idle
//               RELEASE cycle between owners, slave responses routed to the
//               owner only, read data broadcast.
//               Optional macro WSHB_ARB_PREEMPT_EN: an owner that has held
//               the bus for MAX_HOLD cycles while others wait is released at
//               the next acked classic or end-of-burst access.
// Ports       : clk, rst_n (async active-low)
//               s_cyc/s_stb/s_we [NREQ], s_adr [NREQ*ADR_W],
//               s_dat_ms [NREQ*DAT_W], s_sel [NREQ*DAT_W/8],
//               s_cti [NREQ*3], s_bte [NREQ*2]          - from masters
//               s_ack/s_err/s_rty [NREQ], s_dat_sm [DAT_W] - to masters
//               m_cyc/m_stb/m_we, m_adr, m_dat_ms, m_sel, m_cti, m_bte - to slave
//               m_ack/m_err/m_rty, m_dat_sm              - from slave
//               grant [NREQ] - one-hot current owner, 0 when idle
// Revision    : 1.0 - initial release
// ============================================================================
module wshb_rr_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int ADR_W    = 32,
  parameter int DAT_W    = 32,
  parameter int MAX_HOLD = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           s_cyc,
  input  logic [NREQ-1:0]           s_stb,
  input  logic [NREQ-1:0]           s_we,
  input  logic [NREQ*ADR_W-1:0]     s_adr,
  input  logic [NREQ*DAT_W-1:0]     s_dat_ms,
  input  logic [NREQ*(DAT_W/8)-1:0] s_sel,
  input  logic [NREQ*3-1:0]         s_cti,
  input  logic [NREQ*2-1:0]         s_bte,
  output logic [NREQ-1:0]           s_ack,
  output logic [NREQ-1:0]           s_err,
  output logic [NREQ-1:0]           s_rty,
  output logic [DAT_W-1:0]          s_dat_sm,
  output logic                      m_cyc,
  output logic                      m_stb,
  output logic                      m_we,
  output logic [ADR_W-1:0]          m_adr,
  output logic [DAT_W-1:0]          m_dat_ms,
  output logic [DAT_W/8-1:0]        m_sel,
  output logic [2:0]                m_cti,
  output logic [1:0]                m_bte,
  input  logic                      m_ack,
  input  logic                      m_err,
  input  logic                      m_rty,
  input  logic [DAT_W-1:0]          m_dat_sm,
  output logic [NREQ-1:0]           grant
);

  localparam int SEL_W = DAT_W / 8;
  // Reset owner is the highest index so requester 0 wins first.
  localparam logic [NREQ-1:0] OWNER_RST = {1'b1, {(NREQ-1){1'b0}}};

  if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_chk_nreq
    $error("wshb_rr_arbiter: NREQ out of range");
  end
  if (MAX_HOLD < 1) begin : g_chk_hold
    $error("wshb_rr_arbiter: MAX_HOLD must be at least 1");
  end

  arb_state_t      r_state, w_state_nxt;
  logic [NREQ-1:0] r_owner, w_owner_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [NREQ-1:0] w_pick;
  logic            w_owner_cyc;
  logic            w_preempt;

  wshb_rr_picker #(.NREQ(NREQ)) u_picker (
    .req  (s_cyc),
    .last (r_owner),
    .next (w_pick)
  );

  assign w_owner_cyc = |(s_cyc & r_grant);

`ifdef WSHB_ARB_PREEMPT_EN
  localparam int              HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [HOLD_W-1:0] r_hold_cnt;

  // Zero whenever not granted, so the first GRANT cycle reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (r_state != GRANT) begin
      r_hold_cnt <= '0;
    end else if (r_hold_cnt != HOLD_MAX) begin
      r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
    end
  end

  // Only a classic or end-of-burst acked beat is a safe cut point; an
  // incrementing burst is never split.
  assign w_preempt = (r_state == GRANT) && (r_hold_cnt == HOLD_MAX) &&
                     (|(s_cyc & ~r_grant)) && m_ack &&
                     ((m_cti == CTI_CLASSIC) || (m_cti == CTI_EOB));
`else
  assign w_preempt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= OWNER_RST;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  // RELEASE arbitrates exactly like IDLE; it exists to force one cycle with
  // grant=0 between consecutive owners.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_grant_nxt = r_grant;
    case (r_state)
      IDLE, RELEASE: begin
        if (|s_cyc) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_pick;
          w_grant_nxt = w_pick;
        end else begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
        end
      end
      GRANT: begin
        if (!w_owner_cyc || w_preempt) begin
          w_state_nxt = RELEASE;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Owner-to-slave mux, gated by the registered grant (all zero when idle).
  always_comb begin
    m_cyc    = 1'b0;
    m_stb    = 1'b0;
    m_we     = 1'b0;
    m_adr    = '0;
    m_dat_ms = '0;
    m_sel    = '0;
    m_cti    = '0;
    m_bte    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) begin
        m_cyc    = s_cyc[i];
        m_stb    = s_stb[i];
        m_we     = s_we[i];
        m_adr    = s_adr[i*ADR_W +: ADR_W];
        m_dat_ms = s_dat_ms[i*DAT_W +: DAT_W];
        m_sel    = s_sel[i*SEL_W +: SEL_W];
        m_cti    = s_cti[i*3 +: 3];
        m_bte    = s_bte[i*2 +: 2];
      end
    end
  end

  assign s_ack    = r_grant & {NREQ{m_ack}};
  assign s_err    = r_grant & {NREQ{m_err}};
  assign s_rty    = r_grant & {NREQ{m_rty}};
  assign s_dat_sm = m_dat_sm;
  assign grant    = r_grant;

endmodule : wshb_rr_arbiter
`default_nettype wire

// File: tb/tb_wshb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wshb_rr_arbiter
// Description : Self-checking bench for wshb_rr_arbiter. A behavioural model
//               (busy flag, owner index, hold count) predicts every output
//               each cycle; directed steps add explicit spec-timed checks.
//               Preemption steps are compiled in with WSHB_ARB_PREEMPT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wshb_rr_arbiter;

  localparam int NREQ     = 3;
  localparam int ADR_W    = 32;
  localparam int DAT_W    = 32;
  localparam int SEL_W    = DAT_W / 8;
  localparam int MAX_HOLD = 4;
  localparam logic [NREQ-1:0] ONE = 1;
`ifdef WSHB_ARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       s_cyc, s_stb, s_we;
  logic [NREQ*ADR_W-1:0] s_adr;
  logic [NREQ*DAT_W-1:0] s_dat_ms;
  logic [NREQ*SEL_W-1:0] s_sel;
  logic [NREQ*3-1:0]     s_cti;
  logic [NREQ*2-1:0]     s_bte;
  logic [NREQ-1:0]       s_ack, s_err, s_rty;
  logic [DAT_W-1:0]      s_dat_sm;
  logic                  m_cyc, m_stb, m_we;
  logic [ADR_W-1:0]      m_adr;
  logic [DAT_W-1:0]      m_dat_ms;
  logic [SEL_W-1:0]      m_sel;
  logic [2:0]            m_cti;
  logic [1:0]            m_bte;
  logic                  m_ack, m_err, m_rty;
  logic [DAT_W-1:0]      m_dat_sm;
  logic [NREQ-1:0]       grant;

  wshb_rr_arbiter #(
    .NREQ(NREQ), .ADR_W(ADR_W), .DAT_W(DAT_W), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
    .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty), .m_dat_sm(m_dat_sm),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the bus, if anyone, and for how long.
  bit mdl_busy  = 1'b0;
  int mdl_owner = NREQ - 1;
  int mdl_hold  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl_busy  = 1'b0;
    mdl_owner = NREQ - 1;
    mdl_hold  = 0;
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] g;
    int o;
    o = mdl_owner;
    g = mdl_busy ? (ONE << o) : '0;
    chk("grant",    64'(grant),    64'(g));
    chk("m_cyc",    64'(m_cyc),    64'(mdl_busy & s_cyc[o]));
    chk("m_stb",    64'(m_stb),    64'(mdl_busy & s_stb[o]));
    chk("m_we",     64'(m_we),     64'(mdl_busy & s_we[o]));
    chk("m_adr",    64'(m_adr),    mdl_busy ? 64'(s_adr[o*ADR_W +: ADR_W]) : 64'd0);
    chk("m_dat_ms", 64'(m_dat_ms), mdl_busy ? 64'(s_dat_ms[o*DAT_W +: DAT_W]) : 64'd0);
    chk("m_sel",    64'(m_sel),    mdl_busy ? 64'(s_sel[o*SEL_W +: SEL_W]) : 64'd0);
    chk("m_cti",    64'(m_cti),    mdl_busy ? 64'(s_cti[o*3 +: 3]) : 64'd0);
    chk("m_bte",    64'(m_bte),    mdl_busy ? 64'(s_bte[o*2 +: 2]) : 64'd0);
    chk("s_ack",    64'(s_ack),    m_ack ? 64'(g) : 64'd0);
    chk("s_err",    64'(s_err),    m_err ? 64'(g) : 64'd0);
    chk("s_rty",    64'(s_rty),    m_rty ? 64'(g) : 64'd0);
    chk("s_dat_sm", 64'(s_dat_sm), 64'(m_dat_sm));
  endtask

  task automatic model_next(output bit nb, output int no, output int nh);
    logic [NREQ-1:0] own;
    logic [2:0]      cti;
    bit              pre;
    int              idx;
    nb = mdl_busy;
    no = mdl_owner;
    nh = mdl_hold;
    if (mdl_busy) begin
      own = ONE << mdl_owner;
      cti = s_cti[mdl_owner*3 +: 3];
      pre = PREEMPT && (mdl_hold == MAX_HOLD) && ((s_cyc & ~own) != '0) &&
            m_ack && (cti == 3'b000 || cti == 3'b111);
      if (!s_cyc[mdl_owner] || pre) nb = 1'b0;
      else nh = (mdl_hold < MAX_HOLD) ? mdl_hold + 1 : MAX_HOLD;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (mdl_owner + k) % NREQ;
        if (!nb && s_cyc[idx]) begin
          nb = 1'b1;
          no = idx;
          nh = 0;
        end
      end
    end
  endtask

  // One clock: check at negedge, advance model at posedge, return at posedge+1.
  task automatic tick();
    bit nb;
    int no, nh;
    @(negedge clk);
    check_outputs();
    model_next(nb, no, nh);
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      mdl_busy  = nb;
      mdl_owner = no;
      mdl_hold  = nh;
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic v);
    s_cyc[i] = v;
    s_stb[i] = v;
  endtask

  task automatic idle_all();
    s_cyc = '0;
    s_stb = '0;
    m_ack = 1'b0;
    m_err = 1'b0;
    m_rty = 1'b0;
    repeat (3) tick();
  endtask

  // Grant check, one acked access, cyc drop, one-cycle gap check, re-request.
  task automatic serve(input logic [NREQ-1:0] exp_g, input string tag);
    int idx;
    idx = 0;
    for (int i = 0; i < NREQ; i++) if (exp_g[i]) idx = i;
    chk(tag, 64'(grant), 64'(exp_g));
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    set_req(idx, 1'b0);
    tick();
    chk({tag, "_gap"}, 64'(grant), 64'd0);
    set_req(idx, 1'b1);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADR_W-1:0] a;
    bit prev_ack;
    int t;

    s_cyc = '0; s_stb = '0; s_we = '0;
    s_adr = '0; s_dat_ms = '0; s_sel = '0; s_cti = '0; s_bte = '0;
    m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0; m_dat_sm = 32'h1234_5678;

    // 1: reset with all requesting
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'b1);
      s_adr[i*ADR_W +: ADR_W] = 32'h1000_0000 * (i + 1);
    end
    tick();
    tick();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_m_cyc", 64'(m_cyc), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("first_grant", 64'(grant), 64'b001);
    chk("first_m_cyc", 64'(m_cyc), 64'd1);

    // 2: rotation 001,010,100,001
    serve(3'b001, "rot0");
    serve(3'b010, "rot1");
    serve(3'b100, "rot2");
    serve(3'b001, "rot3");

    // 3: isolation of a waiting requester
    idle_all();
    set_req(1, 1'b1);
    tick();
    tick();
    chk("iso_grant", 64'(grant), 64'b010);
    set_req(2, 1'b1);
    for (int p = 0; p < 3; p++) begin
      m_ack = 1'b1;
      #1;
      chk("iso_ack", 64'(s_ack), 64'b010);
      tick();
      m_ack = 1'b0;
      tick();
    end
    set_req(1, 1'b0);
    tick();
    chk("iso_release", 64'(grant), 64'd0);
    tick();
    chk("iso_grant2", 64'(grant), 64'b100);
    m_ack = 1'b1;
    #1;
    chk("iso_ack2", 64'(s_ack), 64'b100);
    tick();

    // 4: single requester regrant latency
    idle_all();
    set_req(0, 1'b1);
    repeat (5) tick();
    chk("single_grant", 64'(grant), 64'b001);
    set_req(0, 1'b0);
    tick();
    chk("single_gap", 64'(grant), 64'd0);
    set_req(0, 1'b1);
    tick();
    chk("single_regrant", 64'(grant), 64'b001);
    a = 32'hCAFE_0040;
    s_adr[0 +: ADR_W] = a;
    #1;
    chk("single_m_adr", 64'(m_adr), 64'(a));
    tick();

    // randomized traffic against the model
    idle_all();
    prev_ack = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!s_cyc[i]) begin
          if ($urandom_range(3) == 0) begin
            set_req(i, 1'b1);
            s_we[i] = 1'($urandom);
            s_adr[i*ADR_W +: ADR_W] = $urandom;
            s_dat_ms[i*DAT_W +: DAT_W] = $urandom;
            s_sel[i*SEL_W +: SEL_W] = 4'($urandom);
            s_cti[i*3 +: 3] = 3'($urandom);
            s_bte[i*2 +: 2] = 2'($urandom);
          end
        end else if (mdl_busy && mdl_owner == i && prev_ack && $urandom_range(1) == 1) begin
          set_req(i, 1'b0);
        end
      end
      m_ack    = 1'($urandom);
      m_err    = ($urandom_range(7) == 0);
      m_rty    = ($urandom_range(7) == 0);
      m_dat_sm = $urandom;
      prev_ack = m_ack;
      tick();
    end

    // async reset mid-transfer
    idle_all();
    s_cti = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1);
    tick();
    tick();
    m_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", 64'(grant), 64'd0);
    chk("arst_m_cyc", 64'(m_cyc), 64'd0);
    chk("arst_m_stb", 64'(m_stb), 64'd0);
    chk("arst_m_adr", 64'(m_adr), 64'd0);
    chk("arst_s_ack", 64'(s_ack), 64'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    m_ack = 1'b0;
    tick();
    tick();
    chk("arst_regrant", 64'(grant), 64'b001);

`ifdef WSHB_ARB_PREEMPT_EN
    // 5: classic streaming hog preempted after quota
    idle_all();
    s_cti = '0;
    set_req(0, 1'b1);
    m_ack = 1'b1;
    tick();
    chk("pre5_grant", 64'(grant), 64'b001);
    t = 0;
    while (t < 20 && grant !== 3'b010) begin
      if (t == 2) set_req(1, 1'b1);
      tick();
      t++;
    end
    chk("pre5_latency", 64'(t), 64'd6);

    // 6: incrementing burst never split
    idle_all();
    s_cti[0 +: 3] = 3'b010;
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    m_ack = 1'b1;
    tick();
    chk("pre6_grant", 64'(grant), 64'b001);
    t = 0;
    while (t < 20 && grant !== 3'b010) begin
      s_cti[0 +: 3] = (t == 7) ? 3'b111 : 3'b010;
      tick();
      t++;
    end
    chk("pre6_latency", 64'(t), 64'd9);
    idle_all();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_wshb_rr_arbiter
`default_nettype wire
